draw_snake: RTL and testbench

- Pipeline stage directly downstream of the background renderer.
- Takes its registered VGA timing and rgb, holds the snake body state, and advances the snake one grid cell per N frames.
- Overlays snake cells on rgb and passes timing through with one cycle of latency.
- Detects wall and self collision and reports game state to the control logic.

---
 rtl/draw_snake.sv | 234 +++++++++++++++++++++++
 tb/tb_draw_snake.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_snake.sv
// draw_snake: pipeline stage after the background renderer. Registers the
// VGA timing, overlays the snake on rgb, steps the snake once every
// MOVE_FRAMES frames and detects wall and self collision.
// Build option: define SNAKE_WRAP_EN to make the field wrap around at its
// edges instead of killing the snake at the wall.
module draw_snake #(
   parameter int GRID_SHIFT  = 4,
   parameter int FIELD_X0    = 13,
   parameter int FIELD_Y0    = 15,
   parameter int FIELD_W     = 38,
   parameter int FIELD_H     = 18,
   parameter int MAX_LEN     = 32,
   parameter int MOVE_FRAMES = 8
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic [10:0] vcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [1:0]  dir_in,
   input  logic        dir_valid,
   input  logic        grow_in,
   input  logic        restart_in,
   output logic [10:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [10:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out,
   output logic [5:0]  head_x,
   output logic [5:0]  head_y,
   output logic [5:0]  snake_len,
   output logic        alive
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int FW = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

   localparam logic [5:0] START_X = 6'(FIELD_X0 + FIELD_W / 2);
   localparam logic [5:0] START_Y = 6'(FIELD_Y0 + FIELD_H / 2);
   localparam logic [5:0] BODY_X  = START_X - 6'd1;
   localparam logic [5:0] TAIL_X  = START_X - 6'd2;
   localparam logic [6:0] X_MIN   = 7'(FIELD_X0);
   localparam logic [6:0] X_MAX   = 7'(FIELD_X0 + FIELD_W - 1);
   localparam logic [6:0] Y_MIN   = 7'(FIELD_Y0);
   localparam logic [6:0] Y_MAX   = 7'(FIELD_Y0 + FIELD_H - 1);
   localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);
   localparam logic [FW-1:0] FRAME_LAST = FW'(MOVE_FRAMES - 1);

   typedef enum logic [1:0] {RUN, MOVE, CHECK, DEAD} state_t;

   state_t        state, state_nx;
   logic [5:0]    seg_x [MAX_LEN];
   logic [5:0]    seg_y [MAX_LEN];
   logic [5:0]    len;
   logic [1:0]    dir, next_dir;
   logic [FW-1:0] frame_cnt;
   logic          move_pending, grow_pending;
   logic [5:0]    chk_idx;

   logic [6:0]    step_x, step_y, nh_x, nh_y;
   logic          wall_hit, self_hit, chk_last, grows, vs_rise, frame_wrap;
   logic [10:0]   cell_x, cell_y;
   logic          is_head, is_body;
   logic [11:0]   pix_rgb;

   assign vs_rise    = vsync_in & ~vsync_out;
   assign frame_wrap = vs_rise && (frame_cnt == FRAME_LAST);
   assign grows      = (grow_pending | grow_in) && (len < LEN_MAX);
   assign self_hit   = (seg_x[IW'(chk_idx)] == seg_x[0]) && (seg_y[IW'(chk_idx)] == seg_y[0]);
   assign chk_last   = (chk_idx == len - 6'd1);
   assign head_x     = seg_x[0];
   assign head_y     = seg_y[0];
   assign snake_len  = len;

   // Candidate head position one cell ahead in next_dir, with field limits
   always_comb begin
      step_x = {1'b0, seg_x[0]};
      step_y = {1'b0, seg_y[0]};
      case (next_dir)
         2'd0:    step_y = step_y - 7'd1;
         2'd1:    step_x = step_x + 7'd1;
         2'd2:    step_y = step_y + 7'd1;
         default: step_x = step_x - 7'd1;
      endcase
      nh_x = step_x;
      nh_y = step_y;
`ifdef SNAKE_WRAP_EN
      wall_hit = 1'b0;
      if (step_x < X_MIN)      nh_x = X_MAX;
      else if (step_x > X_MAX) nh_x = X_MIN;
      if (step_y < Y_MIN)      nh_y = Y_MAX;
      else if (step_y > Y_MAX) nh_y = Y_MIN;
`else
      wall_hit = (step_x < X_MIN) || (step_x > X_MAX) ||
                 (step_y < Y_MIN) || (step_y > Y_MAX);
`endif
   end

   // Pixel mux: head over body over background, blanking passes rgb_in
   always_comb begin
      cell_x  = hcount_in >> GRID_SHIFT;
      cell_y  = vcount_in >> GRID_SHIFT;
      is_head = (cell_x == {5'd0, seg_x[0]}) && (cell_y == {5'd0, seg_y[0]});
      is_body = 1'b0;
      for (int unsigned k = 1; k < MAX_LEN; k++) begin
         if ((k < 32'(len)) && (cell_x == {5'd0, seg_x[IW'(k)]}) &&
             (cell_y == {5'd0, seg_y[IW'(k)]}))
            is_body = 1'b1;
      end
      if (hblnk_in | vblnk_in) pix_rgb = rgb_in;
      else if (is_head)        pix_rgb = (state == DEAD) ? 12'hf00 : 12'h080;
      else if (is_body)        pix_rgb = 12'h0f0;
      else                     pix_rgb = rgb_in;
   end

   // Timing pass-through and composited colour, one cycle of latency
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hcount_out <= '0;
         hsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vcount_out <= '0;
         vsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= hcount_in;
         hsync_out  <= hsync_in;
         hblnk_out  <= hblnk_in;
         vcount_out <= vcount_in;
         vsync_out  <= vsync_in;
         vblnk_out  <= vblnk_in;
         rgb_out    <= pix_rgb;
      end
   end

   // FSM state register
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nx;
   end

   // FSM next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         RUN:   if (move_pending) state_nx = MOVE;
         MOVE:  state_nx = wall_hit ? DEAD : CHECK;
         CHECK: begin
            if (self_hit)      state_nx = DEAD;
            else if (chk_last) state_nx = RUN;
         end
         DEAD:  if (restart_in) state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   // FSM outputs
   always_comb begin
      alive = (state != DEAD);
   end

   // Control registers: frame pacing, direction, growth and check index
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         len          <= 6'd3;
         dir          <= 2'd1;
         next_dir     <= 2'd1;
         frame_cnt    <= '0;
         move_pending <= 1'b0;
         grow_pending <= 1'b0;
         chk_idx      <= 6'd1;
      end else if (state == DEAD) begin
         frame_cnt <= '0;
         if (restart_in) begin
            len          <= 6'd3;
            dir          <= 2'd1;
            next_dir     <= 2'd1;
            move_pending <= 1'b0;
            grow_pending <= 1'b0;
            chk_idx      <= 6'd1;
         end
      end else begin
         if (dir_valid && (dir_in != (dir ^ 2'd2))) next_dir <= dir_in;
         if (grow_in) grow_pending <= 1'b1;
         if (vs_rise) frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
         // a wrap landing on the same edge as the RUN->MOVE hand-off must not be lost
         if (state == RUN) move_pending <= 1'b0;
         if (frame_wrap)   move_pending <= 1'b1;
         case (state)
            MOVE: begin
               dir          <= next_dir;
               grow_pending <= 1'b0;
               chk_idx      <= 6'd1;
               // growth only applies to a step that actually happens
               if (!wall_hit && grows) len <= len + 6'd1;
            end
            CHECK:   chk_idx <= chk_idx + 6'd1;
            default: ;
         endcase
      end
   end

   // Segment storage: reload on reset/restart, shift on a legal step
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < MAX_LEN; k++) begin
            seg_x[IW'(k)] <= (k == 0) ? START_X : (k == 1) ? BODY_X : TAIL_X;
            seg_y[IW'(k)] <= START_Y;
         end
      end else if (state == DEAD) begin
         if (restart_in) begin
            for (int unsigned k = 0; k < MAX_LEN; k++) begin
               seg_x[IW'(k)] <= (k == 0) ? START_X : (k == 1) ? BODY_X : TAIL_X;
               seg_y[IW'(k)] <= START_Y;
            end
         end
      end else if ((state == MOVE) && !wall_hit) begin
         for (int unsigned k = 0; k + 1 < MAX_LEN; k++) begin
            seg_x[IW'(k + 1)] <= seg_x[IW'(k)];
            seg_y[IW'(k + 1)] <= seg_y[IW'(k)];
         end
         seg_x[0] <= nh_x[5:0];
         seg_y[0] <= nh_y[5:0];
      end
   end

endmodule

// File: tb/tb_draw_snake.sv
// Bench for draw_snake: queue-based snake model plus per-cycle compare of
// timing, pixel colour and game state, and literal spot checks.
module tb_draw_snake;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] hcount_in = '0, vcount_in = '0;
   logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0;
   logic [1:0]  dir_in = '0;
   logic        dir_valid = 1'b0, grow_in = 1'b0, restart_in = 1'b0;

   logic [10:0] hcount_out, vcount_out, hcount_o2, vcount_o2;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
   logic        hsync_o2, hblnk_o2, vsync_o2, vblnk_o2;
   logic [11:0] rgb_out, rgb_o2;
   logic [5:0]  head_x, head_y, snake_len, head_x2, head_y2, snake_len2;
   logic        alive, alive2;

   always #5 clk = ~clk;

   draw_snake #(.MOVE_FRAMES(2)) dut (
      .pclk(clk), .rst(rst), .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
      .dir_in(dir_in), .dir_valid(dir_valid), .grow_in(grow_in), .restart_in(restart_in),
      .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .head_x(head_x), .head_y(head_y), .snake_len(snake_len), .alive(alive));

   // Small-storage instance sharing the stimulus, used for the length cap
   draw_snake #(.MAX_LEN(4), .MOVE_FRAMES(2)) dut2 (
      .pclk(clk), .rst(rst), .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
      .dir_in(dir_in), .dir_valid(dir_valid), .grow_in(grow_in), .restart_in(restart_in),
      .hcount_out(hcount_o2), .hsync_out(hsync_o2), .hblnk_out(hblnk_o2),
      .vcount_out(vcount_o2), .vsync_out(vsync_o2), .vblnk_out(vblnk_o2),
      .rgb_out(rgb_o2), .head_x(head_x2), .head_y(head_y2), .snake_len(snake_len2), .alive(alive2));

   int errors = 0;
   int checks = 0;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int mx[$], my[$];
   int m_dir, m_next, m_frames;
   bit m_alive, m_grow;

   task automatic m_reset();
      mx = {32, 31, 30};
      my = {24, 24, 24};
      m_dir = 1; m_next = 1; m_frames = 0; m_alive = 1; m_grow = 0;
   endtask

   task automatic m_step();
      int nx, ny;
      bit g;
      nx = mx[0]; ny = my[0];
      m_dir = m_next;
      case (m_dir)
         0: ny = ny - 1;
         1: nx = nx + 1;
         2: ny = ny + 1;
         default: nx = nx - 1;
      endcase
      g = m_grow; m_grow = 0;
`ifdef SNAKE_WRAP_EN
      if (nx < 13) nx = 50; else if (nx > 50) nx = 13;
      if (ny < 15) ny = 32; else if (ny > 32) ny = 15;
`else
      if (nx < 13 || nx > 50 || ny < 15 || ny > 32) begin m_alive = 0; return; end
`endif
      mx.push_front(nx); my.push_front(ny);
      if (!(g && mx.size() <= 32)) begin void'(mx.pop_back()); void'(my.pop_back()); end
      for (int i = 1; i < mx.size(); i++)
         if (mx[i] == nx && my[i] == ny) m_alive = 0;
   endtask

   task automatic m_tick();
      if (!m_alive) return;
      m_frames++;
      if (m_frames == 2) begin m_frames = 0; m_step(); end
   endtask

   function automatic logic [11:0] m_pixel(int h, int v, bit blank, logic [11:0] rgb);
      int cx = h >> 4;
      int cy = v >> 4;
      if (blank) return rgb;
      if (cx == mx[0] && cy == my[0]) return m_alive ? 12'h080 : 12'hf00;
      for (int i = 1; i < mx.size(); i++)
         if (cx == mx[i] && cy == my[i]) return 12'h0f0;
      return rgb;
   endfunction

   // ---------------- per-cycle compare ----------------
   bit          chk_en = 0, have_exp = 0;
   logic [10:0] e_h, e_v;
   logic        e_hs, e_hb, e_vs, e_vb;
   logic [11:0] e_rgb;

   always @(negedge clk) begin
      if (chk_en && have_exp) begin
         check("hcount_out", int'(hcount_out), int'(e_h));
         check("vcount_out", int'(vcount_out), int'(e_v));
         check("hsync_out",  int'(hsync_out),  int'(e_hs));
         check("hblnk_out",  int'(hblnk_out),  int'(e_hb));
         check("vsync_out",  int'(vsync_out),  int'(e_vs));
         check("vblnk_out",  int'(vblnk_out),  int'(e_vb));
         check("rgb_out",    int'(rgb_out),    int'(e_rgb));
         check("head_x",     int'(head_x),     mx[0]);
         check("head_y",     int'(head_y),     my[0]);
         check("snake_len",  int'(snake_len),  mx.size());
         check("alive",      int'(alive),      int'(m_alive));
      end
      if (chk_en) begin
         e_h = hcount_in; e_v = vcount_in; e_hs = hsync_in; e_hb = hblnk_in;
         e_vs = vsync_in; e_vb = vblnk_in;
         e_rgb = m_pixel(int'(hcount_in), int'(vcount_in), hblnk_in | vblnk_in, rgb_in);
         have_exp = 1;
      end else begin
         have_exp = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic set_pix(int h, int v, bit blank, logic [11:0] rgb);
      hcount_in = 11'(h); vcount_in = 11'(v); hblnk_in = blank; vblnk_in = 1'b0; rgb_in = rgb;
      cyc(1);
   endtask

   task automatic scan(int cx, int cy);
      for (int y = cy - 2; y <= cy + 2; y++)
         for (int x = cx - 3; x <= cx + 3; x++) begin
            hcount_in = 11'(x * 16 + int'($urandom_range(0, 15)));
            vcount_in = 11'(y * 16 + int'($urandom_range(0, 15)));
            hblnk_in  = ($urandom_range(0, 7) == 0);
            vblnk_in  = ($urandom_range(0, 9) == 0);
            hsync_in  = 1'($urandom_range(0, 1));
            rgb_in    = 12'($urandom);
            cyc(1);
         end
      hblnk_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b0;
   endtask

   task automatic do_reset();
      chk_en = 0;
      rst = 1'b1; m_reset();
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk_en = 1;
   endtask

   task automatic vs_tick();
      vsync_in = 1'b1; m_tick(); cyc(2);
      vsync_in = 1'b0; cyc(2);
   endtask

   task automatic step_frames(int n);
      chk_en = 0;
      repeat (n) vs_tick();
      cyc(40);
      chk_en = 1;
      cyc(2);
   endtask

   task automatic req_dir(int d);
      dir_valid = 1'b1; dir_in = 2'(d);
      if (m_alive && d != (m_dir ^ 2)) m_next = d;
      cyc(1);
      dir_valid = 1'b0;
   endtask

   task automatic pulse_grow();
      grow_in = 1'b1;
      if (m_alive) m_grow = 1;
      cyc(1);
      grow_in = 1'b0;
   endtask

   task automatic pulse_restart();
      chk_en = 0;
      restart_in = 1'b1;
      if (!m_alive) m_reset();
      cyc(1);
      restart_in = 1'b0;
      cyc(1);
      chk_en = 1;
      cyc(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   int n;

   initial begin
      m_reset();
      // asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      check("rst_head_x", int'(head_x), 32);
      check("rst_head_y", int'(head_y), 24);
      check("rst_len", int'(snake_len), 3);
      check("rst_alive", int'(alive), 1);
      check("rst_rgb", int'(rgb_out), 0);
      check("rst_hcount", int'(hcount_out), 0);
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk_en = 1;

      // pixel mux and timing latency
      set_pix(512, 384, 0, 12'hfff); check("pix_head", int'(rgb_out), 'h080);
      set_pix(480, 384, 0, 12'hfff); check("pix_body", int'(rgb_out), 'h0f0);
      set_pix(464, 384, 0, 12'hfff); check("pix_bg", int'(rgb_out), 'hfff);
      set_pix(512, 384, 1, 12'h123); check("pix_blank", int'(rgb_out), 'h123);
      hsync_in = 1'b1;
      check("hsync_pre", int'(hsync_out), 0);
      cyc(1);
      check("hsync_delay", int'(hsync_out), 1);
      hsync_in = 1'b0;
      cyc(1);
      check("hsync_fall", int'(hsync_out), 0);
      scan(32, 24);

      // free running steps
      step_frames(2); check("step1_x", int'(head_x), 33);
      step_frames(2); check("step2_x", int'(head_x), 34);
      check("step2_y", int'(head_y), 24);
      check("step2_len", int'(snake_len), 3);
      scan(33, 24);
      restart_in = 1'b1; cyc(1); restart_in = 1'b0; cyc(2);
      check("restart_ignored", int'(head_x), 34);

      // reversal ignored, then turn up
      do_reset();
      req_dir(3);
      req_dir(0);
      step_frames(2);
      check("turn_x", int'(head_x), 32);
      check("turn_y", int'(head_y), 23);

      // growth and the length cap
      do_reset();
      pulse_grow();
      step_frames(2);
      check("grow_len", int'(snake_len), 4);
      check("grow_len_cap4", int'(snake_len2), 4);
      set_pix(30 * 16 + 5, 24 * 16 + 5, 0, 12'hfff); check("tail_kept", int'(rgb_out), 'h0f0);
      set_pix(29 * 16 + 5, 24 * 16 + 5, 0, 12'hfff); check("past_tail", int'(rgb_out), 'hfff);
      scan(31, 24);
      pulse_grow();
      step_frames(2);
      check("grow_len5", int'(snake_len), 5);
      check("grow_cap_drop", int'(snake_len2), 4);

      // self collision: up, left, down into own body
      req_dir(0); step_frames(2);
      req_dir(3); step_frames(2);
      req_dir(2);
      chk_en = 0;
      vs_tick();
      vsync_in = 1'b1; m_tick();
      n = 0;
      while (alive && n < 40) begin @(posedge clk); #1; n++; end
      vsync_in = 1'b0;
      check("self_hit_in_time", int'(!alive && n <= 7), 1);
      cyc(40);
      chk_en = 1;
      cyc(2);
      check("dead_head_x", int'(head_x), 33);
      check("dead_head_y", int'(head_y), 24);
      set_pix(33 * 16 + 8, 24 * 16 + 8, 0, 12'hfff); check("dead_red", int'(rgb_out), 'hf00);
      scan(33, 24);
      step_frames(2);
      check("dead_frozen", int'(head_x), 33);
      pulse_restart();
      check("restart_x", int'(head_x), 32);
      check("restart_alive", int'(alive), 1);

      // asynchronous reset in the middle of CHECK
      hcount_in = '0; vcount_in = '0; rgb_in = 12'hfff;
      chk_en = 0;
      vs_tick();
      vsync_in = 1'b1;
      cyc(3);
      check("mid_check_moved", int'(head_x), 33);
      rst = 1'b1;
      #1;
      check("arst_head_x", int'(head_x), 32);
      check("arst_len", int'(snake_len), 3);
      check("arst_alive", int'(alive), 1);
      check("arst_rgb", int'(rgb_out), 0);
      check("arst_vsync", int'(vsync_out), 0);
      vsync_in = 1'b0;
      m_reset();
      cyc(1);
      rst = 1'b0;
      cyc(1);
      chk_en = 1;
      cyc(1);

      // wall: run right to the last column, then one more step
      repeat (18) step_frames(2);
      check("wall_reach", int'(head_x), 50);
      scan(49, 24);
      step_frames(2);
`ifdef SNAKE_WRAP_EN
      check("wrap_x", int'(head_x), 13);
      check("wrap_alive", int'(alive), 1);
`else
      check("wall_x", int'(head_x), 50);
      check("wall_y", int'(head_y), 24);
      check("wall_alive", int'(alive), 0);
      set_pix(50 * 16 + 3, 24 * 16 + 3, 0, 12'hfff); check("wall_red", int'(rgb_out), 'hf00);
`endif
      scan(50, 24);
      pulse_restart();
`ifdef SNAKE_WRAP_EN
      check("wall_restart_x", int'(head_x), 13);
`else
      check("wall_restart_x", int'(head_x), 32);
`endif
      check("wall_restart_alive", int'(alive), 1);
      scan(32, 24);

      chk_en = 0;
      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
